rx_cic_chain: RTL and testbench
===============================

RX_CIC_CHAIN -- requirements
Module: rx_cic_chain

Interface
REQ-001 Parameter IWIDTH, 16, I/Q input sample width (signed two's complement).
REQ-002 Parameter OWIDTH, 16, I/Q output sample width (signed).
REQ-003 Parameter N_STAGES, 4, CIC integrator/comb stage count, range 1..6.
REQ-004 Parameter RATEADDR, 0, serial address of rate register.
REQ-005 Parameter CTRLADDR, 1, serial address of control register.
REQ-006 Internal accumulator width AW = IWIDTH + 8*N_STAGES; port widths derive from the parameters above.
REQ-007 clock  in  1  single clock; all state on rising edge.
REQ-008 reset  in  1  asynchronous, active-low; all state cleared while low.
REQ-009 enable  in  1  high = run; low = synchronous clear of datapath state, registers kept.
REQ-010 serial_addr  in  7  config register address.
REQ-011 serial_data  in  32  config write data.
REQ-012 serial_strobe  in  1  one-cycle write qualifier.
REQ-013 strobe_in  in  1  input sample valid, one cycle per sample.
REQ-014 i_in, q_in  in  IWIDTH each  input samples, sampled when strobe_in high.
REQ-015 strobe_out  out  1  one-cycle pulse, i_out/q_out valid.
REQ-016 i_out, q_out  out  OWIDTH each  decimated samples, held between strobes.
REQ-017 overflow  out  1  sticky saturation flag.

Function
REQ-018 Rate register bits[7:0] = decimation R; R of 0 or 1 SHALL behave as R=1 (each strobe_in yields a strobe_out), with integrators/combs still active.
REQ-019 Control register: bit0 bypass, bit1 round_en, bits[12:8] shift S (0..31), bit16 overflow clear (self-clearing, not stored).
REQ-020 Register writes take effect the cycle after serial_strobe with matching address; other addresses ignored.
REQ-021 A write to RATEADDR SHALL clear decimation counter, integrators and combs (flush); outputs hold last value.
REQ-022 On each strobe_in (enable high): N_STAGES cascaded integrators update, AW-bit wrap-around arithmetic, sign-extended input.
REQ-023 Decimation counter counts strobe_in 0..R-1; on the strobe_in where counter = R-1 it wraps to 0 and the last integrator value enters the comb chain.
REQ-024 Comb chain: N_STAGES differentiators, delay of one decimated sample each, AW-bit wrap-around.
REQ-025 Scaling: comb result arithmetically shifted right by S; if round_en, add 2^(S-1) before shift (no add when S=0).
REQ-026 Saturation: scaled value outside OWIDTH signed range clamps to max/min; overflow set on any I or Q clamp, cleared only by reset or bit16 write; set wins if same cycle.
REQ-027 Latency: strobe_out SHALL assert exactly 2 clocks after the strobe_in completing a decimation period; i_out/q_out update same cycle.
REQ-028 Bypass: i_out/q_out = sign-extended/truncated-saturated i_in/q_in, strobe_out 1 clock after strobe_in; CIC state held cleared.
REQ-029 I and Q paths SHALL be identical and independent; q_out never depends on i_in.
REQ-030 strobe_in on consecutive cycles SHALL be supported (full throughput, one sample per clock).
REQ-031 enable low: counter, integrators, combs, pipeline cleared, strobe_out low; i_out/q_out hold.

Reset
REQ-032 reset low: R=1, bypass=0, round_en=0, S=0, overflow=0, strobe_out=0, i_out=q_out=0, all accumulators/counter 0.
REQ-033 Reset asserted mid-decimation discards partial sums; first strobe_out after release follows a full R-sample period.

Verification
REQ-034 N=4, R=4, S=0, constant i_in=1, q_in=-1 continuous strobes -> after settling i_out=256, q_out=-256, strobe_out every 4th cycle, 2 clocks after period end.
REQ-035 Bypass=1, i_in=0x1234 with strobe_in -> i_out=0x1234, strobe_out exactly 1 clock later.
REQ-036 R=16, S=0, i_in=32767 constant -> i_out=32767, overflow=1; write bit16 with clamp absent -> overflow=0.
REQ-037 R=4, S=8, round_en=1, i_in=1 -> i_out=1 (256>>8); S=9 round_en=1 -> 1, round_en=0 -> 0.
REQ-038 Rate write R=8 mid-period -> no strobe_out until 8 new strobe_in, outputs held meanwhile.
REQ-039 reset pulsed low mid-period -> all outputs 0 immediately (async), config defaults, normal operation after release.

Source files
------------

// File: rtl/rx_cic_chain.sv
// rx_cic_chain -- I/Q CIC decimator with a serial-bus configuration port.
//
// Each I/Q sample passes through N_STAGES cascaded integrators. Every R-th
// sample feeds N_STAGES comb differentiators. The comb result is then
// shifted right by S (optionally rounded) and saturated to OWIDTH. The
// decimated result appears 2 clocks after the sample that completes a period.
// In bypass mode the input is saturated straight to the output 1 clock later.
//
// Ports:
//   clock         single clock, rising edge
//   reset         asynchronous active-low reset
//   enable        1 = run, 0 = clear datapath state (config and outputs kept)
//   serial_addr   config register address (7 bits)
//   serial_data   config write data (32 bits)
//   serial_strobe one-cycle write qualifier
//   strobe_in     input sample valid
//   i_in, q_in    signed input samples (IWIDTH)
//   strobe_out    one-cycle pulse, i_out/q_out updated
//   i_out, q_out  signed decimated samples (OWIDTH), held between strobes
//   overflow      sticky saturation flag
//
// Registers:
//   RATEADDR  [7:0] decimation R (0 and 1 both mean R=1); a write flushes the CIC
//   CTRLADDR  [0] bypass, [1] round_en, [12:8] shift S, [16] overflow clear
module rx_cic_chain #(
  parameter int IWIDTH   = 16,
  parameter int OWIDTH   = 16,
  parameter int N_STAGES = 4,
  parameter int RATEADDR = 0,
  parameter int CTRLADDR = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [6:0]        serial_addr,
  input  logic [31:0]       serial_data,
  input  logic              serial_strobe,
  input  logic              strobe_in,
  input  logic [IWIDTH-1:0] i_in,
  input  logic [IWIDTH-1:0] q_in,
  output logic              strobe_out,
  output logic [OWIDTH-1:0] i_out,
  output logic [OWIDTH-1:0] q_out,
  output logic              overflow
);

  localparam int AW = IWIDTH + 8 * N_STAGES;
  localparam logic [6:0] RATE_A = 7'(RATEADDR);
  localparam logic [6:0] CTRL_A = 7'(CTRLADDR);

  logic [7:0] rate_q;
  logic       bypass_q;
  logic       round_q;
  logic [4:0] shift_q;
  logic       rate_wr;
  logic       ctrl_wr;
  logic       flush;
  logic [7:0] cnt_last;
  logic       unused_data;

  // Channel index 0 = I, 1 = Q; both channels share identical logic.
  logic signed [AW-1:0] x_ext     [2];
  logic [7:0]           cnt_p0;
  logic signed [AW-1:0] integ_p0  [2][N_STAGES];
  logic signed [AW-1:0] integ_nxt [2][N_STAGES];
  logic signed [AW-1:0] samp_p0   [2];
  logic                 vld_p0;
  logic signed [AW-1:0] comb_d_p1 [2][N_STAGES];
  logic signed [AW-1:0] diff      [2][N_STAGES];
  logic [OWIDTH:0]      cic_sat   [2];
  logic [OWIDTH:0]      byp_sat   [2];

  // Optional round-half-up, then arithmetic right shift by s.
  // One extra bit keeps the rounding add from wrapping.
  function automatic logic signed [AW:0] round_shift(input logic signed [AW-1:0] v,
                                                     input logic rnd,
                                                     input logic [4:0] s);
    logic signed [AW:0] t;
    t = {v[AW-1], v};
    if (rnd && (s != 5'd0)) t = t + ((AW+1)'(1) << (s - 5'd1));
    return t >>> s;
  endfunction

  // Returns {clamped, value} with value limited to the OWIDTH signed range.
  function automatic logic [OWIDTH:0] saturate(input logic signed [AW:0] v);
    logic signed [AW:0] hi;
    logic signed [AW:0] lo;
    hi = {{(AW-OWIDTH+2){1'b0}}, {(OWIDTH-1){1'b1}}};
    lo = {{(AW-OWIDTH+2){1'b1}}, {(OWIDTH-1){1'b0}}};
    if (v > hi) return {1'b1, 1'b0, {(OWIDTH-1){1'b1}}};
    else if (v < lo) return {1'b1, 1'b1, {(OWIDTH-1){1'b0}}};
    else return {1'b0, v[OWIDTH-1:0]};
  endfunction

  assign rate_wr  = serial_strobe && (serial_addr == RATE_A);
  assign ctrl_wr  = serial_strobe && (serial_addr == CTRL_A);
  assign cnt_last = (rate_q == 8'd0) ? 8'd0 : rate_q - 8'd1;
  // Any of these holds the CIC state at zero.
  assign flush    = !enable || bypass_q || rate_wr;
  assign unused_data = ^{serial_data[31:17], serial_data[15:13]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rate_q   <= 8'd1;
      bypass_q <= 1'b0;
      round_q  <= 1'b0;
      shift_q  <= 5'd0;
    end else begin
      if (rate_wr) rate_q <= serial_data[7:0];
      if (ctrl_wr) begin
        bypass_q <= serial_data[0];
        round_q  <= serial_data[1];
        shift_q  <= serial_data[12:8];
      end
    end
  end

  always_comb begin
    x_ext[0] = {{(AW-IWIDTH){i_in[IWIDTH-1]}}, i_in};
    x_ext[1] = {{(AW-IWIDTH){q_in[IWIDTH-1]}}, q_in};
    for (int c = 0; c < 2; c++) begin
      integ_nxt[c][0] = integ_p0[c][0] + x_ext[c];
      for (int k = 1; k < N_STAGES; k++)
        integ_nxt[c][k] = integ_p0[c][k] + integ_nxt[c][k-1];
      diff[c][0] = samp_p0[c] - comb_d_p1[c][0];
      for (int k = 1; k < N_STAGES; k++)
        diff[c][k] = diff[c][k-1] - comb_d_p1[c][k];
      cic_sat[c] = saturate(round_shift(diff[c][N_STAGES-1], round_q, shift_q));
      byp_sat[c] = saturate({x_ext[c][AW-1], x_ext[c]});
    end
  end

  // Stage p0: integrators and decimation counter; p1: comb delay lines.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_p0 <= 8'd0;
      vld_p0 <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        samp_p0[c] <= '0;
        for (int k = 0; k < N_STAGES; k++) begin
          integ_p0[c][k]  <= '0;
          comb_d_p1[c][k] <= '0;
        end
      end
    end else if (flush) begin
      cnt_p0 <= 8'd0;
      vld_p0 <= 1'b0;
      for (int c = 0; c < 2; c++)
        for (int k = 0; k < N_STAGES; k++) begin
          integ_p0[c][k]  <= '0;
          comb_d_p1[c][k] <= '0;
        end
    end else begin
      vld_p0 <= 1'b0;
      if (strobe_in) begin
        for (int c = 0; c < 2; c++)
          for (int k = 0; k < N_STAGES; k++)
            integ_p0[c][k] <= integ_nxt[c][k];
        if (cnt_p0 == cnt_last) begin
          cnt_p0 <= 8'd0;
          vld_p0 <= 1'b1;
          for (int c = 0; c < 2; c++)
            samp_p0[c] <= integ_nxt[c][N_STAGES-1];
        end else begin
          cnt_p0 <= cnt_p0 + 8'd1;
        end
      end
      if (vld_p0) begin
        for (int c = 0; c < 2; c++) begin
          comb_d_p1[c][0] <= samp_p0[c];
          for (int k = 1; k < N_STAGES; k++)
            comb_d_p1[c][k] <= diff[c][k-1];
        end
      end
    end
  end

  // Stage p1 output register: comb result or bypass sample.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      strobe_out <= 1'b0;
      i_out      <= '0;
      q_out      <= '0;
      overflow   <= 1'b0;
    end else begin
      strobe_out <= 1'b0;
      if (ctrl_wr && serial_data[16]) overflow <= 1'b0;
      if (enable) begin
        if (bypass_q) begin
          if (strobe_in) begin
            strobe_out <= 1'b1;
            i_out      <= byp_sat[0][OWIDTH-1:0];
            q_out      <= byp_sat[1][OWIDTH-1:0];
            if (byp_sat[0][OWIDTH] || byp_sat[1][OWIDTH]) overflow <= 1'b1;
          end
        end else if (vld_p0 && !rate_wr) begin
          strobe_out <= 1'b1;
          i_out      <= cic_sat[0][OWIDTH-1:0];
          q_out      <= cic_sat[1][OWIDTH-1:0];
          if (cic_sat[0][OWIDTH] || cic_sat[1][OWIDTH]) overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_cic_chain.sv
module tb_rx_cic_chain;

  localparam logic [6:0] RATE_A = 7'd0;
  localparam logic [6:0] CTRL_A = 7'd1;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic        serial_strobe;
  logic        strobe_in;
  logic [15:0] i_in;
  logic [15:0] q_in;
  logic        strobe_out;
  logic [15:0] i_out;
  logic [15:0] q_out;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  rx_cic_chain dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .serial_addr   (serial_addr),
    .serial_data   (serial_data),
    .serial_strobe (serial_strobe),
    .strobe_in     (strobe_in),
    .i_in          (i_in),
    .q_in          (q_in),
    .strobe_out    (strobe_out),
    .i_out         (i_out),
    .q_out         (q_out),
    .overflow      (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic write_reg(input logic [6:0] a, input logic [31:0] d);
    serial_addr   = a;
    serial_data   = d;
    serial_strobe = 1'b1;
    strobe_in     = 1'b0;
    step();
    serial_strobe = 1'b0;
  endtask

  task automatic stream(input int n, input logic [15:0] iv, input logic [15:0] qv,
                        input int idle);
    for (int k = 0; k < n; k++) begin
      strobe_in = 1'b1;
      i_in      = iv;
      q_in      = qv;
      step();
    end
    strobe_in = 1'b0;
    for (int k = 0; k < idle; k++) step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    checks++;
    if (strobe_out !== 1'b0) begin errors++; $display("FAIL reset_strobe got=%b exp=0", strobe_out); end
    checks++;
    if (i_out !== 16'h0000) begin errors++; $display("FAIL reset_i got=%h exp=0000", i_out); end
    checks++;
    if (q_out !== 16'h0000) begin errors++; $display("FAIL reset_q got=%h exp=0000", q_out); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    #2 reset = 1'b1;
    step();
  endtask

  // R=0 acts as R=1: every strobe yields an output of gain 1, 2 clocks later.
  task automatic test_unity_rate();
    logic exp_so;
    write_reg(RATE_A, 32'd0);
    for (int j = 0; j < 5; j++) begin
      strobe_in = (j < 4);
      i_in      = 16'd1;
      q_in      = 16'hFFFF;
      step();
      exp_so = (j >= 1) && (j <= 4);
      checks++;
      if (strobe_out !== exp_so) begin errors++; $display("FAIL unity_strobe cyc=%0d got=%b exp=%b", j, strobe_out, exp_so); end
      if (exp_so) begin
        checks++;
        if (i_out !== 16'd1 || q_out !== 16'hFFFF) begin
          errors++;
          $display("FAIL unity_value cyc=%0d got i=%0d q=%0d exp i=1 q=-1", j, $signed(i_out), $signed(q_out));
        end
      end
    end
  endtask

  // N=4, R=4: outputs 35, 190, 255 then settle at 256 (gain R^N).
  task automatic test_decimate();
    int   exp_v [7] = '{0, 35, 190, 255, 256, 256, 256};
    logic exp_so;
    int   m;
    write_reg(RATE_A, 32'd4);
    write_reg(CTRL_A, 32'd0);
    for (int j = 0; j < 26; j++) begin
      strobe_in = (j < 24);
      i_in      = 16'd1;
      q_in      = 16'hFFFF;
      step();
      exp_so = (j >= 4) && (j % 4 == 0);
      checks++;
      if (strobe_out !== exp_so) begin errors++; $display("FAIL dec_strobe cyc=%0d got=%b exp=%b", j, strobe_out, exp_so); end
      if (exp_so) begin
        m = j / 4;
        checks++;
        if (i_out !== 16'(exp_v[m]) || q_out !== 16'(-exp_v[m])) begin
          errors++;
          $display("FAIL dec_value out=%0d got i=%0d q=%0d exp i=%0d q=%0d", m,
                   $signed(i_out), $signed(q_out), exp_v[m], -exp_v[m]);
        end
      end
    end
  endtask

  task automatic test_scaling();
    write_reg(RATE_A, 32'd4);
    write_reg(CTRL_A, 32'h0000_0802);  // S=8, round
    stream(28, 16'd1, 16'hFFFF, 2);
    checks++;
    if (i_out !== 16'd1 || q_out !== 16'hFFFF) begin
      errors++;
      $display("FAIL scale_s8_rnd got i=%0d q=%0d exp i=1 q=-1", $signed(i_out), $signed(q_out));
    end
    write_reg(CTRL_A, 32'h0000_0902);  // S=9, round
    stream(8, 16'd1, 16'hFFFF, 2);
    checks++;
    if (i_out !== 16'd1 || q_out !== 16'd0) begin
      errors++;
      $display("FAIL scale_s9_rnd got i=%0d q=%0d exp i=1 q=0", $signed(i_out), $signed(q_out));
    end
    write_reg(CTRL_A, 32'h0000_0900);  // S=9, truncate
    stream(8, 16'd1, 16'hFFFF, 2);
    checks++;
    if (i_out !== 16'd0 || q_out !== 16'hFFFF) begin
      errors++;
      $display("FAIL scale_s9_trunc got i=%0d q=%0d exp i=0 q=-1", $signed(i_out), $signed(q_out));
    end
  endtask

  // Outputs are i=0, q=-1 on entry; a mid-period rate write restarts the count.
  task automatic test_rate_change();
    logic exp_so;
    write_reg(CTRL_A, 32'd0);
    stream(2, 16'd1, 16'hFFFF, 0);
    write_reg(RATE_A, 32'd8);
    for (int j = 0; j < 10; j++) begin
      strobe_in = (j < 8);
      i_in      = 16'd1;
      q_in      = 16'hFFFF;
      step();
      exp_so = (j == 8);
      checks++;
      if (strobe_out !== exp_so) begin errors++; $display("FAIL rate_strobe cyc=%0d got=%b exp=%b", j, strobe_out, exp_so); end
      if (j < 8) begin
        checks++;
        if (i_out !== 16'd0 || q_out !== 16'hFFFF) begin
          errors++;
          $display("FAIL rate_hold cyc=%0d got i=%0d q=%0d exp i=0 q=-1", j, $signed(i_out), $signed(q_out));
        end
      end
      if (exp_so) begin
        checks++;
        if (i_out !== 16'd330 || q_out !== 16'(-330)) begin
          errors++;
          $display("FAIL rate_value got i=%0d q=%0d exp i=330 q=-330", $signed(i_out), $signed(q_out));
        end
      end
    end
  endtask

  task automatic test_overflow();
    write_reg(RATE_A, 32'd16);
    stream(48, 16'h7FFF, 16'h8000, 2);
    checks++;
    if (i_out !== 16'h7FFF || q_out !== 16'h8000) begin
      errors++;
      $display("FAIL ovf_clamp got i=%h q=%h exp i=7fff q=8000", i_out, q_out);
    end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    write_reg(CTRL_A, 32'd0);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    write_reg(CTRL_A, 32'h0001_0000);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask

  // Outputs are 7fff/8000 on entry; enable low discards the partial period.
  task automatic test_enable();
    logic exp_so;
    write_reg(RATE_A, 32'd4);
    stream(2, 16'd1, 16'hFFFF, 0);
    enable = 1'b0;
    for (int j = 0; j < 3; j++) begin
      strobe_in = 1'b1;
      step();
      checks++;
      if (strobe_out !== 1'b0 || i_out !== 16'h7FFF) begin
        errors++;
        $display("FAIL en_low cyc=%0d got strobe=%b i=%h exp strobe=0 i=7fff", j, strobe_out, i_out);
      end
    end
    strobe_in = 1'b0;
    enable    = 1'b1;
    for (int j = 0; j < 5; j++) begin
      strobe_in = (j < 4);
      step();
      exp_so = (j == 4);
      checks++;
      if (strobe_out !== exp_so) begin errors++; $display("FAIL en_strobe cyc=%0d got=%b exp=%b", j, strobe_out, exp_so); end
      if (exp_so) begin
        checks++;
        if (i_out !== 16'd35 || q_out !== 16'(-35)) begin
          errors++;
          $display("FAIL en_value got i=%0d q=%0d exp i=35 q=-35", $signed(i_out), $signed(q_out));
        end
      end
    end
  endtask

  task automatic test_bypass();
    write_reg(CTRL_A, 32'd1);
    strobe_in = 1'b1;
    i_in      = 16'h1234;
    q_in      = 16'hFFFB;
    step();
    checks++;
    if (strobe_out !== 1'b1 || i_out !== 16'h1234 || q_out !== 16'hFFFB) begin
      errors++;
      $display("FAIL byp_first got strobe=%b i=%h q=%h exp strobe=1 i=1234 q=fffb", strobe_out, i_out, q_out);
    end
    i_in = 16'h8000;
    q_in = 16'h7FFF;
    step();
    checks++;
    if (strobe_out !== 1'b1 || i_out !== 16'h8000 || q_out !== 16'h7FFF) begin
      errors++;
      $display("FAIL byp_b2b got strobe=%b i=%h q=%h exp strobe=1 i=8000 q=7fff", strobe_out, i_out, q_out);
    end
    strobe_in = 1'b0;
    step();
    checks++;
    if (strobe_out !== 1'b0 || i_out !== 16'h8000 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL byp_idle got strobe=%b i=%h ovf=%b exp strobe=0 i=8000 ovf=0", strobe_out, i_out, overflow);
    end
    write_reg(CTRL_A, 32'd0);
  endtask

  task automatic test_reset_mid();
    logic exp_so;
    write_reg(RATE_A, 32'd4);
    write_reg(CTRL_A, 32'h0000_0102);  // S=1, round
    stream(4, 16'd1, 16'hFFFF, 2);
    checks++;
    if (i_out !== 16'd18 || q_out !== 16'(-17)) begin
      errors++;
      $display("FAIL rst_pre got i=%0d q=%0d exp i=18 q=-17", $signed(i_out), $signed(q_out));
    end
    stream(2, 16'd1, 16'hFFFF, 0);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (strobe_out !== 1'b0 || i_out !== 16'd0 || q_out !== 16'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_async got strobe=%b i=%h q=%h ovf=%b exp all 0", strobe_out, i_out, q_out, overflow);
    end
    #2 reset = 1'b1;
    // Defaults now: R=1, S=0, no rounding.
    for (int j = 0; j < 4; j++) begin
      strobe_in = (j < 3);
      i_in      = 16'd1;
      q_in      = 16'hFFFF;
      step();
      exp_so = (j >= 1);
      checks++;
      if (strobe_out !== exp_so) begin errors++; $display("FAIL rst_strobe cyc=%0d got=%b exp=%b", j, strobe_out, exp_so); end
      if (exp_so) begin
        checks++;
        if (i_out !== 16'd1 || q_out !== 16'hFFFF) begin
          errors++;
          $display("FAIL rst_value cyc=%0d got i=%0d q=%0d exp i=1 q=-1", j, $signed(i_out), $signed(q_out));
        end
      end
    end
  endtask

  initial begin
    reset         = 1'b0;
    enable        = 1'b1;
    serial_addr   = 7'd0;
    serial_data   = 32'd0;
    serial_strobe = 1'b0;
    strobe_in     = 1'b0;
    i_in          = 16'd0;
    q_in          = 16'd0;
    test_reset();
    test_unity_rate();
    test_decimate();
    test_scaling();
    test_rate_change();
    test_overflow();
    test_enable();
    test_bypass();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
